// File: rtl/dual_fwd_hazard_unit_if.sv
// Decode-to-EX hazard bus: ID-stage tags and pipeline control in,
// per-lane operand bypass selects and issue-control flags out.
interface dual_fwd_hazard_unit_if #(
  parameter int LANES      = 2,
  parameter int AW         = 5,
  parameter int FWD_STAGES = 2,
  parameter int SELW       = $clog2(1 + FWD_STAGES*LANES)
) ();
  logic                  hold_i;
  logic                  flush_i;
  logic [LANES-1:0]      id_valid_i;
  logic [LANES-1:0]      id_we_i;
  logic [LANES-1:0]      id_load_i;
  logic [LANES*AW-1:0]   id_rd_i;
  logic [LANES*AW-1:0]   id_rs_i;
  logic [LANES*AW-1:0]   id_rt_i;
  logic [LANES*SELW-1:0] fwd_a_o;
  logic [LANES*SELW-1:0] fwd_b_o;
  logic                  load_use_stall_o;
  logic                  split_o;

  modport master (
    output hold_i, flush_i, id_valid_i, id_we_i, id_load_i, id_rd_i, id_rs_i, id_rt_i,
    input  fwd_a_o, fwd_b_o, load_use_stall_o, split_o
  );

  modport slave (
    input  hold_i, flush_i, id_valid_i, id_we_i, id_load_i, id_rd_i, id_rs_i, id_rt_i,
    output fwd_a_o, fwd_b_o, load_use_stall_o, split_o
  );
endinterface

// File: rtl/dual_fwd_hazard_unit.sv
// Forwarding / load-use hazard unit for the dual-issue pipeline. Tracks a shadow
// pipeline of destination tags (EX plus FWD_STAGES forwarding stages) per lane.
module dual_fwd_hazard_unit #(
  parameter int LANES      = 2,
  parameter int AW         = 5,
  parameter int FWD_STAGES = 2,
  parameter int SELW       = $clog2(1 + FWD_STAGES*LANES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dual_fwd_hazard_unit_if.slave bus
);

  // Index 0 is EX, index s is post-EX stage s.
  logic [FWD_STAGES:0][LANES-1:0]         vld_pipe;
  logic [FWD_STAGES:0][LANES-1:0]         we_pipe;
  logic [FWD_STAGES:0][LANES-1:0][AW-1:0] rd_pipe;
  logic [LANES-1:0]                       ex_load;
  logic [LANES-1:0][AW-1:0]               ex_rs, ex_rt;

  logic [LANES-1:0][AW-1:0] id_rd, id_rs, id_rt;
  logic                     load_use_stall;
  logic [LANES-1:0]         ex_vld_nxt;

  assign id_rd = bus.id_rd_i;
  assign id_rs = bus.id_rs_i;
  assign id_rt = bus.id_rt_i;

  assign ex_vld_nxt = (load_use_stall || bus.flush_i) ? '0 : bus.id_valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      we_pipe  <= '0;
      rd_pipe  <= '0;
      ex_load  <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
    end else if (!bus.hold_i) begin
      vld_pipe <= {vld_pipe[FWD_STAGES-1:0], ex_vld_nxt};
      we_pipe  <= {we_pipe[FWD_STAGES-1:0], bus.id_we_i};
      rd_pipe  <= {rd_pipe[FWD_STAGES-1:0], id_rd};
      ex_load  <= bus.id_load_i;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
    end
  end

  // No EX-to-EX path, so a load in EX feeding any valid ID source must wait.
  always_comb begin
    load_use_stall = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      for (int p = 0; p < LANES; p++) begin
        if (bus.id_valid_i[l] && vld_pipe[0][p] && we_pipe[0][p] && ex_load[p] &&
            rd_pipe[0][p] != '0 &&
            (rd_pipe[0][p] == id_rs[l] || rd_pipe[0][p] == id_rt[l]))
          load_use_stall = 1'b1;
      end
    end
  end

  assign bus.load_use_stall_o = load_use_stall;

  if (LANES >= 2) begin : g_split
    assign bus.split_o = bus.id_valid_i[0] && bus.id_valid_i[1] && bus.id_we_i[0] &&
                         id_rd[0] != '0 && (id_rd[0] == id_rs[1] || id_rd[0] == id_rt[1]);
  end else begin : g_nosplit
    assign bus.split_o = 1'b0;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [SELW-1:0] sel_a, sel_b;

    // Scan oldest stage first and lane 0 first so the youngest stage and the
    // later lane within a stage overwrite earlier hits.
    always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int s = FWD_STAGES; s >= 1; s--) begin
        for (int p = 0; p < LANES; p++) begin
          if (vld_pipe[s][p] && we_pipe[s][p] && rd_pipe[s][p] != '0) begin
            if (rd_pipe[s][p] == ex_rs[l]) sel_a = SELW'(1 + (s-1)*LANES + p);
            if (rd_pipe[s][p] == ex_rt[l]) sel_b = SELW'(1 + (s-1)*LANES + p);
          end
        end
      end
      if (!vld_pipe[0][l]) begin
        sel_a = '0;
        sel_b = '0;
      end
    end

    assign bus.fwd_a_o[l*SELW +: SELW] = sel_a;
    assign bus.fwd_b_o[l*SELW +: SELW] = sel_b;
  end

endmodule

// File: tb/tb_dual_fwd_hazard_unit.sv
// Bench for dual_fwd_hazard_unit: directed vector table, reset sequence, then
// random traffic checked against a bundle-history reference model.
module tb_dual_fwd_hazard_unit;
  localparam int LANES = 2;
  localparam int AW    = 5;
  localparam int FWD   = 2;
  localparam int SELW  = 3;

  typedef struct packed {
    logic [1:0]      vld, we, ld;
    logic [1:0][4:0] rd, rs, rt;
  } bnd_t;

  typedef struct {
    int h, f, vld, we, ld, rd0, rd1, rs0, rs1, rt0, rt1, a0, a1, b0, b1, st, sp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  bnd_t hist[$];  // hist[0] = bundle in EX, hist[s] = bundle in stage s
  vec_t tbl[$];

  dual_fwd_hazard_unit_if #(.LANES(LANES), .AW(AW), .FWD_STAGES(FWD), .SELW(SELW)) bus ();

  dual_fwd_hazard_unit #(.LANES(LANES), .AW(AW), .FWD_STAGES(FWD), .SELW(SELW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  function automatic bnd_t mkb(int vld, int we, int ld, int rd0, int rd1,
                               int rs0, int rs1, int rt0, int rt1);
    bnd_t b;
    b.vld = 2'(vld); b.we = 2'(we); b.ld = 2'(ld);
    b.rd[0] = 5'(rd0); b.rd[1] = 5'(rd1);
    b.rs[0] = 5'(rs0); b.rs[1] = 5'(rs1);
    b.rt[0] = 5'(rt0); b.rt[1] = 5'(rt1);
    return b;
  endfunction

  task automatic apply(input bnd_t b, input bit h, input bit f);
    bus.hold_i     = h;
    bus.flush_i    = f;
    bus.id_valid_i = b.vld;
    bus.id_we_i    = b.we;
    bus.id_load_i  = b.ld;
    bus.id_rd_i    = b.rd;
    bus.id_rs_i    = b.rs;
    bus.id_rt_i    = b.rt;
  endtask

  function automatic int sel_of(input int l, input bit is_b);
    return is_b ? int'(bus.fwd_b_o[l*SELW +: SELW]) : int'(bus.fwd_a_o[l*SELW +: SELW]);
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= FWD; i++) hist.push_back('0);
  endtask

  // Youngest producer first; within one bundle the later lane is the newer write.
  function automatic int exp_sel(input int l, input logic [4:0] t);
    if (!hist[0].vld[l] || t == 0) return 0;
    for (int s = 1; s <= FWD; s++)
      for (int p = LANES - 1; p >= 0; p--)
        if (hist[s].vld[p] && hist[s].we[p] && hist[s].rd[p] == t)
          return 1 + (s - 1) * LANES + p;
    return 0;
  endfunction

  function automatic int exp_stall(input bnd_t id);
    for (int l = 0; l < LANES; l++)
      for (int p = 0; p < LANES; p++)
        if (id.vld[l] && hist[0].vld[p] && hist[0].we[p] && hist[0].ld[p] &&
            hist[0].rd[p] != 0 && (hist[0].rd[p] == id.rs[l] || hist[0].rd[p] == id.rt[l]))
          return 1;
    return 0;
  endfunction

  function automatic int exp_split(input bnd_t id);
    return int'(id.vld[0] && id.vld[1] && id.we[0] && id.rd[0] != 0 &&
                (id.rd[0] == id.rs[1] || id.rd[0] == id.rt[1]));
  endfunction

  task automatic mstep(input bnd_t b, input bit h, input bit f, input int idx);
    int es;
    apply(b, h, f);
    #1;
    es = exp_stall(b);
    for (int l = 0; l < LANES; l++) begin
      chk("rnd fwd_a", idx, sel_of(l, 1'b0), exp_sel(l, hist[0].rs[l]));
      chk("rnd fwd_b", idx, sel_of(l, 1'b1), exp_sel(l, hist[0].rt[l]));
    end
    chk("rnd stall", idx, int'(bus.load_use_stall_o), es);
    chk("rnd split", idx, int'(bus.split_o), exp_split(b));
    @(posedge clk);
    if (!h) begin
      bnd_t n;
      n = b;
      if (es != 0 || f) n.vld = '0;
      hist.push_front(n);
      void'(hist.pop_back());
    end
    #1;
  endtask

  // ---------------- directed vectors ----------------
  task automatic fill_table();
    // h f vld we ld rd0 rd1 rs0 rs1 rt0 rt1 | a0 a1 b0 b1 st sp
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0});
    tbl.push_back('{0,0,1,1,0, 5,0,0,0,0,0, 0,0,0,0,0,0});  // producer r5
    tbl.push_back('{0,0,1,0,0, 0,0,5,0,0,0, 0,0,0,0,0,0});  // consumer rs=r5
    tbl.push_back('{1,0,0,0,0, 0,0,0,0,0,0, 1,0,0,0,0,0});  // held x3
    tbl.push_back('{1,0,0,0,0, 0,0,0,0,0,0, 1,0,0,0,0,0});
    tbl.push_back('{1,1,0,0,0, 0,0,0,0,0,0, 1,0,0,0,0,0});  // hold beats flush
    tbl.push_back('{0,0,1,0,0, 0,0,5,0,0,0, 1,0,0,0,0,0});  // later consumer
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0,0, 3,0,0,0,0,0});  // stage 2 lane 0
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0});
    tbl.push_back('{0,0,3,3,0, 7,7,0,0,0,0, 0,0,0,0,0,0});  // both lanes write r7
    tbl.push_back('{0,0,1,0,0, 0,0,0,0,7,0, 0,0,0,0,0,0});
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0,0, 0,0,2,0,0,0});  // stage 1 lane 1 wins
    tbl.push_back('{0,0,2,2,0, 0,7,0,0,0,0, 0,0,0,0,0,0});
    tbl.push_back('{0,0,1,1,0, 7,0,0,0,0,0, 0,0,0,0,0,0});
    tbl.push_back('{0,0,1,0,0, 0,0,0,0,7,0, 0,0,0,0,0,0});
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0,0, 0,0,1,0,0,0});  // stage 1 beats stage 2
    tbl.push_back('{0,0,3,1,0, 0,3,0,0,0,0, 0,0,0,0,0,0});  // rd=r0 we / rd=r3 no-we
    tbl.push_back('{0,0,3,0,0, 0,0,0,3,3,0, 0,0,0,0,0,0});
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0});
    tbl.push_back('{0,0,2,2,2, 0,9,0,0,0,0, 0,0,0,0,0,0});  // load r9 lane 1
    tbl.push_back('{0,0,1,0,0, 0,0,9,0,0,0, 0,0,0,0,1,0});  // load-use stall
    tbl.push_back('{0,0,1,0,0, 0,0,9,0,0,0, 0,0,0,0,0,0});  // bubble in EX
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0,0, 4,0,0,0,0,0});  // load now in stage 2
    tbl.push_back('{0,0,3,1,0, 4,0,0,0,0,4, 0,0,0,0,0,1});  // split
    tbl.push_back('{0,0,3,1,0, 0,0,0,0,0,0, 0,0,0,0,0,0});  // rd=r0 no split
    tbl.push_back('{0,1,1,1,0, 6,0,0,0,0,0, 0,0,0,0,0,0});  // flushed producer
    tbl.push_back('{0,0,1,0,0, 0,0,6,0,0,0, 0,0,0,0,0,0});
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0});
  endtask

  initial begin
    vec_t v;
    bnd_t b;
    rst_n = 1'b0;
    apply(mkb(3,1,0, 4,0, 0,0, 0,4), 1'b0, 1'b0);
    #3;
    chk("rst fwd_a", 0, int'(bus.fwd_a_o), 0);
    chk("rst fwd_b", 0, int'(bus.fwd_b_o), 0);
    chk("rst stall", 0, int'(bus.load_use_stall_o), 0);
    chk("rst split", 0, int'(bus.split_o), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst hold fwd_a", 1, int'(bus.fwd_a_o), 0);
    apply('0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    fill_table();
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      b = mkb(v.vld, v.we, v.ld, v.rd0, v.rd1, v.rs0, v.rs1, v.rt0, v.rt1);
      apply(b, v.h[0], v.f[0]);
      #1;
      chk("vec fwd_a0", i, sel_of(0, 1'b0), v.a0);
      chk("vec fwd_a1", i, sel_of(1, 1'b0), v.a1);
      chk("vec fwd_b0", i, sel_of(0, 1'b1), v.b0);
      chk("vec fwd_b1", i, sel_of(1, 1'b1), v.b1);
      chk("vec stall",  i, int'(bus.load_use_stall_o), v.st);
      chk("vec split",  i, int'(bus.split_o), v.sp);
      @(posedge clk);
      #1;
    end

    // Mid-stream asynchronous reset with a live forward.
    apply(mkb(1,1,0, 5,0, 0,0, 0,0), 1'b0, 1'b0);
    @(posedge clk); #1;
    apply(mkb(1,0,0, 0,0, 5,0, 0,0), 1'b0, 1'b0);
    @(posedge clk); #1;
    apply('0, 1'b0, 1'b0);
    #1;
    chk("pre-rst fwd_a0", 0, sel_of(0, 1'b0), 1);
    rst_n = 1'b0;
    #1;
    chk("async rst fwd_a", 0, int'(bus.fwd_a_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    mstep(mkb(1,0,0, 0,0, 5,0, 0,0), 1'b0, 1'b0, 0);
    chk("no stale fwd_a0", 0, sel_of(0, 1'b0), 0);
    mstep('0, 1'b0, 1'b0, 1);

    for (int i = 0; i < 400; i++) begin
      b.vld = 2'($urandom_range(0, 3));
      b.we  = 2'($urandom_range(0, 3));
      b.ld  = 2'($urandom_range(0, 3));
      for (int l = 0; l < LANES; l++) begin
        b.rd[l] = 5'($urandom_range(0, 3));
        b.rs[l] = 5'($urandom_range(0, 3));
        b.rt[l] = 5'($urandom_range(0, 3));
      end
      mstep(b, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, i + 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
